// File: rtl/debounce_pulse_gen.sv
// Push-button debouncer: 2-flop synchronizer, four-state qualification FSM,
// registered debounced level and single-cycle enable strobe per accepted press.
module debounce_pulse_gen #(
  parameter int unsigned DB_CYCLES        = 4,
  parameter bit          PULSE_ON_RELEASE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic en_pulse,
  output logic btn_level,
  output logic busy
);

  localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             pulse_d, level_d;
  logic             btn_m, btn_s;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_in;
      btn_s <= btn_m;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE_LO;
      cnt       <= '0;
      en_pulse  <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      en_pulse  <= pulse_d;
      btn_level <= level_d;
    end
  end

  // Next-state logic; cnt only advances while qualifying and is zero otherwise
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    pulse_d = 1'b0;
    case (state)
      IDLE_LO: begin
        if (btn_s) state_d = CHK_HI;
      end
      CHK_HI: begin
        if (!btn_s) begin
          state_d = IDLE_LO;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE_HI;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!btn_s) state_d = CHK_LO;
      end
      CHK_LO: begin
        if (btn_s) begin
          state_d = IDLE_HI;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE_LO;
          pulse_d = PULSE_ON_RELEASE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
      end
    endcase
    level_d = (state_d == IDLE_HI) || (state_d == CHK_LO);
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Randomized and directed bench for debounce_pulse_gen, press-only and
// press+release variants driven from one button, checked against a run-length model.
module tb_debounce_pulse_gen;

  localparam int DB = 4;

  logic clk;
  logic reset_n;
  logic btn_in;
  logic en_pulse0, btn_level0, busy0;
  logic en_pulse1, btn_level1, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_pulse_gen #(.DB_CYCLES(DB), .PULSE_ON_RELEASE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
    .en_pulse(en_pulse0), .btn_level(btn_level0), .busy(busy0)
  );

  debounce_pulse_gen #(.DB_CYCLES(DB), .PULSE_ON_RELEASE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
    .en_pulse(en_pulse1), .btn_level(btn_level1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a level change is accepted once the synchronized input has
  // disagreed with the debounced level on DB+1 consecutive clock edges.
  logic m_s1, m_s2, m_level, m_p0, m_p1;
  int   m_run;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0;
      m_p0 <= 1'b0; m_p1 <= 1'b0; m_run <= 0;
    end else begin
      m_s1 <= btn_in;
      m_s2 <= m_s1;
      if (m_s2 != m_level) begin
        if (m_run == DB) begin
          m_level <= m_s2;
          m_run   <= 0;
          m_p0    <= m_s2;
          m_p1    <= 1'b1;
        end else begin
          m_run <= m_run + 1;
          m_p0  <= 1'b0;
          m_p1  <= 1'b0;
        end
      end else begin
        m_run <= 0;
        m_p0  <= 1'b0;
        m_p1  <= 1'b0;
      end
    end
  end

  // Downstream mod-8 state counter enabled by the press-only strobe
  logic [2:0] cnt8;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt8 <= 3'd0;
    else          cnt8 <= cnt8 + 3'(en_pulse0);
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      chk("model_pulse0", en_pulse0, m_p0);
      chk("model_pulse1", en_pulse1, m_p1);
      chk("model_level0", btn_level0, m_level);
      chk("model_level1", btn_level1, m_level);
      chk("model_busy0", busy0, m_run != 0);
      chk("model_busy1", busy1, m_run != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_in = 1'b0;
    repeat (12) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_in  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  int np0, np1, pedge, nbusy, fbusy, maxlvl;
  logic [2:0] exp8;

  initial begin
    reset_n = 1'b0;
    btn_in  = 1'b0;
    repeat (2) tick();
    chk("rst_pulse0", en_pulse0, 1'b0);
    chk("rst_level0", btn_level0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_pulse1", en_pulse1, 1'b0);
    reset_n = 1'b1;
    settle();

    // Clean press held 20 cycles
    btn_in = 1'b1;
    np0 = 0; np1 = 0; pedge = 0; nbusy = 0; fbusy = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (en_pulse0) begin np0++; pedge = k; end
      if (en_pulse1) np1++;
      if (busy0) begin nbusy++; if (fbusy == 0) fbusy = k; end
      if (k == 6) chk("clean_level_e6", btn_level0, 1'b0);
      if (k == 7) chk("clean_level_e7", btn_level0, 1'b1);
    end
    chk_int("clean_npulse0", np0, 1);
    chk_int("clean_npulse1", np1, 1);
    chk_int("clean_pulse_edge", pedge, 7);
    chk_int("clean_busy_cycles", nbusy, 4);
    chk_int("clean_busy_first", fbusy, 3);
    settle();

    // Three-cycle glitch
    np0 = 0; maxlvl = 0;
    btn_in = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) btn_in = 1'b0;
      tick();
      if (en_pulse0 || en_pulse1) np0++;
      if (btn_level0) maxlvl = 1;
    end
    chk_int("glitch_npulse", np0, 0);
    chk_int("glitch_level_seen", maxlvl, 0);
    chk("glitch_busy_end", busy0, 1'b0);
    settle();

    // Bounce 1,0,1,1,0,1 then stable high
    np0 = 0; pedge = 0;
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 5; i >= 1; i--) begin
        btn_in = pat[i];
        tick();
        if (en_pulse0) np0++;
      end
    end
    btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (en_pulse0) begin np0++; pedge = k; end
    end
    chk_int("bounce_npulse", np0, 1);
    chk_int("bounce_pulse_edge", pedge, 7);
    settle();

    // Press then release, 10 cycles each
    np0 = 0; np1 = 0;
    btn_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 11) btn_in = 1'b0;
      tick();
      if (en_pulse0) np0++;
      if (en_pulse1) np1++;
    end
    chk_int("release_npulse0", np0, 1);
    chk_int("release_npulse1", np1, 2);
    chk("release_level0", btn_level0, 1'b0);
    chk("release_level1", btn_level1, 1'b0);
    settle();

    // Reset mid-qualification, then button held through reset release
    btn_in = 1'b1;
    repeat (5) tick();
    chk("midq_busy", busy0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midq_rst_pulse", en_pulse0, 1'b0);
    chk("midq_rst_level", btn_level0, 1'b0);
    chk("midq_rst_busy", busy0, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    np0 = 0; pedge = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (en_pulse0) begin np0++; pedge = k; end
    end
    chk_int("held_rst_pulse_edge", pedge, 7);
    chk_int("held_rst_npulse", np0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("pulse_drop_on_reset", en_pulse0, 1'b0);
    btn_in = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    settle();

    // Eight presses drive the mod-8 counter through a full wrap
    do_reset();
    np0 = 0;
    for (int i = 0; i < 8; i++) begin
      btn_in = 1'b1;
      for (int k = 0; k < 10; k++) begin tick(); if (en_pulse0) np0++; end
      btn_in = 1'b0;
      for (int k = 0; k < 10; k++) begin tick(); if (en_pulse0) np0++; end
      exp8 = 3'(i + 1);
      chk_int("mod8_step", int'(cnt8), int'(exp8));
    end
    chk_int("mod8_npulse", np0, 8);
    chk_int("mod8_wrap", int'(cnt8), 0);

    // Random bouncy runs with occasional resets
    do_reset();
    for (int r = 0; r < 400; r++) begin
      btn_in = ~btn_in;
      repeat ($urandom_range(1, 9)) tick();
      if ($urandom_range(0, 39) == 0) begin
        #2 reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset_n = 1'b1;
      end
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_gen.md
DEBOUNCE_PULSE_GEN -- requirements
Module: debounce_pulse_gen

Interface
REQ-001 Parameter: DB_CYCLES, 4, consecutive synchronized-stable cycles required to accept a level change; legal range 2..65535.
REQ-002 Parameter: PULSE_ON_RELEASE, 0, 1 = also emit en_pulse on an accepted release; 0 = press only.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset; assertion immediate, deassertion sampled on clk.
REQ-005 Port: btn_in  input  1  raw, bouncy, asynchronous push-button level; 1 = pressed.
REQ-006 Port: en_pulse  output  1  registered single-cycle strobe per accepted press; drives the enable of the downstream 3-bit mod-8 state counter.
REQ-007 Port: btn_level  output  1  registered debounced button level.
REQ-008 Port: busy  output  1  high while a level change is being qualified (CHK_HI or CHK_LO).

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer; only its second-stage output btn_s is used by the block.
REQ-010 FSM SHALL have exactly four states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO; unused encodings SHALL return to IDLE_LO on the next edge.
REQ-011 IDLE_LO: btn_s=1 -> CHK_HI with qualification counter cnt cleared to 0; else remain.
REQ-012 CHK_HI: btn_s=0 -> IDLE_LO, no pulse, btn_level unchanged (bounce rejected); btn_s=1 and cnt<DB_CYCLES-1 -> cnt+1; btn_s=1 and cnt=DB_CYCLES-1 -> IDLE_HI.
REQ-013 IDLE_HI: btn_s=0 -> CHK_LO with cnt cleared to 0; else remain.
REQ-014 CHK_LO: mirror of CHK_HI with polarity inverted; btn_s=1 -> IDLE_HI, completion -> IDLE_LO.
REQ-015 cnt SHALL be wide enough to hold DB_CYCLES-1, SHALL never wrap, and SHALL hold 0 in IDLE states.
REQ-016 btn_level SHALL be 1 in IDLE_HI and CHK_LO, 0 in IDLE_LO and CHK_HI.
REQ-017 en_pulse SHALL be 1 for exactly the one cycle following the CHK_HI->IDLE_HI transition edge; with PULSE_ON_RELEASE=1, also the cycle following CHK_LO->IDLE_LO.
REQ-018 Latency: if btn_in rises before edge E and stays high, en_pulse SHALL be high during the cycle after edge E+DB_CYCLES+2 (E counts as edge 1: edges 1-2 synchronizer, edge 3 enter CHK_HI, edges 4..DB_CYCLES+2 count, edge DB_CYCLES+3 accept).
REQ-019 en_pulse SHALL never be high in two consecutive cycles; minimum spacing between pulses is DB_CYCLES+1 cycles.
REQ-020 Holding btn_in high indefinitely SHALL produce exactly one pulse (no auto-repeat).
REQ-021 A glitch of fewer than DB_CYCLES synchronized cycles SHALL not change btn_level, en_pulse or the IDLE state reached afterwards.
REQ-022 busy SHALL be combinationally decoded from state only (no btn_in path).

Reset
REQ-023 While reset_n=0: synchronizer flops=0, state=IDLE_LO, cnt=0, en_pulse=0, btn_level=0, busy=0.
REQ-024 Reset asserted mid-qualification SHALL abort it with no pulse; reset asserted in the en_pulse cycle SHALL drop en_pulse immediately.
REQ-025 Button held through reset release SHALL be treated as a new press: qualifies and pulses per REQ-018 timing.

Verification
REQ-026 DB_CYCLES=4; btn_in 0->1 clean, held 20 cycles -> en_pulse high exactly once, in cycle after edge 7; btn_level=1 from same edge; busy high edges 3-6.
REQ-027 DB_CYCLES=4; btn_in pulses high 3 cycles then low -> no en_pulse, btn_level stays 0, state returns IDLE_LO.
REQ-028 DB_CYCLES=4; bounce pattern 1,0,1,1,0,1 then stable 1 -> single en_pulse 7 edges after final stable rise sampled; count of pulses =1.
REQ-029 PULSE_ON_RELEASE=0 vs 1; press then release, each stable 10 cycles -> 1 vs 2 en_pulse strobes; btn_level returns 0 in both.
REQ-030 Reset asserted at cnt=2 of CHK_HI -> all outputs 0 immediately; after release with btn_in held 1 -> pulse 7 edges later.
REQ-031 Eight accepted presses into downstream mod-8 counter -> counter advances 0..7 and wraps to 0; exactly 8 en_pulse strobes observed.
